// File: rtl/xfire_fpu_bkm_ctrl.sv
// ---------------------------------------------------------------------------
// xfire_fpu_bkm_ctrl
//
// Purpose: sequencing controller for a BKM (exp/log) iterative datapath.
//   A request accepted in IDLE produces one LOAD cycle, then exactly N_ITER
//   ITER cycles with the shift index n = 0 .. N_ITER-1, then one DONE cycle.
//   The operation can be cancelled by abort and frozen by enable.
//
// Parameters:
//   N_ITER  iterations per operation (2 .. 2**IDX_W)
//   IDX_W   width of the iteration index
//
// Ports:
//   clk          in   clock, rising edge
//   srst         in   synchronous active-high reset, overrides every other input
//   enable       in   clock enable; low freezes state, index and captured mode
//   start        in   operation request, honoured only in IDLE
//   mode         in   0 = E-mode (exp), 1 = L-mode (log); captured on acceptance
//   abort        in   cancels an operation in LOAD or ITER
//   ready        out  high in IDLE
//   busy         out  high in LOAD or ITER
//   done         out  one-cycle pulse, result valid in the datapath
//   dp_load      out  operand-load strobe
//   dp_iter_en   out  iteration strobe
//   dp_iter_idx  out  current iteration index (shift amount)
//   dp_mode      out  captured mode, stable from LOAD through DONE
//   op_cnt       out  (XFIRE_BKM_CTRL_STATS_EN only) saturating count of
//                     completed operations
//
// Configuration macro: XFIRE_BKM_CTRL_STATS_EN adds the op_cnt counter/port.
//
// Strobe timing: every output is a flop or a decode of the state flop.
// A strobe is raised in the cycle after the edge that enters its state, and
// only if enable was high at that edge. A state that is frozen by enable=0
// therefore presents its strobe exactly once; the datapath acts on each
// strobe cycle without needing to look at enable itself.
// ---------------------------------------------------------------------------
module xfire_fpu_bkm_ctrl #(
  parameter int N_ITER = 32,
  parameter int IDX_W  = 5
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             enable,
  input  logic             start,
  input  logic             mode,
  input  logic             abort,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             dp_load,
  output logic             dp_iter_en,
  output logic [IDX_W-1:0] dp_iter_idx,
  output logic             dp_mode
`ifdef XFIRE_BKM_CTRL_STATS_EN
  ,
  output logic [15:0]      op_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ITER = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0] LP_IDX_LAST = IDX_W'(N_ITER - 1);
  localparam logic [IDX_W-1:0] LP_IDX_ZERO = {IDX_W{1'b0}};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_nxt;
  logic             r_mode;
  logic             w_mode_nxt;
  logic             r_load;
  logic             r_iter_en;
  logic             r_done;
  logic             w_load_nxt;
  logic             w_iter_en_nxt;
  logic             w_done_nxt;

  // Next-state, next-index and captured-mode logic; enable=0 holds everything.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_mode_nxt  = r_mode;
    if (enable) begin
      case (r_state)
        ST_IDLE: begin
          // abort in IDLE only blocks a simultaneous start
          if (start && !abort) begin
            w_state_nxt = ST_LOAD;
            w_mode_nxt  = mode;
            w_idx_nxt   = LP_IDX_ZERO;
          end else begin
            w_idx_nxt   = LP_IDX_ZERO;
          end
        end
        ST_LOAD: begin
          if (abort) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_ITER;
          end
          w_idx_nxt = LP_IDX_ZERO;
        end
        ST_ITER: begin
          if (abort) begin
            w_state_nxt = ST_IDLE;
            w_idx_nxt   = LP_IDX_ZERO;
          end else if (r_idx == LP_IDX_LAST) begin
            // last iteration: leave ITER instead of wrapping the index
            w_state_nxt = ST_DONE;
            w_idx_nxt   = LP_IDX_ZERO;
          end else begin
            w_idx_nxt   = r_idx + {{(IDX_W-1){1'b0}}, 1'b1};
          end
        end
        ST_DONE: begin
          w_state_nxt = ST_IDLE;
          w_idx_nxt   = LP_IDX_ZERO;
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_idx_nxt   = LP_IDX_ZERO;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_mode_nxt  = r_mode;
    end
  end

  // Strobes for the state being entered; a frozen edge yields no strobe.
  always_comb begin
    w_load_nxt    = 1'b0;
    w_iter_en_nxt = 1'b0;
    w_done_nxt    = 1'b0;
    if (enable) begin
      w_load_nxt    = (w_state_nxt == ST_LOAD);
      w_iter_en_nxt = (w_state_nxt == ST_ITER);
      w_done_nxt    = (w_state_nxt == ST_DONE);
    end else begin
      w_load_nxt    = 1'b0;
      w_iter_en_nxt = 1'b0;
      w_done_nxt    = 1'b0;
    end
  end

  // State, index, mode and strobe registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (srst) begin
      r_state   <= ST_IDLE;
      r_idx     <= LP_IDX_ZERO;
      r_mode    <= 1'b0;
      r_load    <= 1'b0;
      r_iter_en <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_mode    <= w_mode_nxt;
      r_load    <= w_load_nxt;
      r_iter_en <= w_iter_en_nxt;
      r_done    <= w_done_nxt;
    end
  end

  assign ready       = (r_state == ST_IDLE);
  assign busy        = (r_state == ST_LOAD) || (r_state == ST_ITER);
  assign done        = r_done;
  assign dp_load     = r_load;
  assign dp_iter_en  = r_iter_en;
  assign dp_iter_idx = r_idx;
  assign dp_mode     = r_mode;

`ifdef XFIRE_BKM_CTRL_STATS_EN
  logic [15:0] r_op_cnt;

  // Completed-operation counter; aborted operations never reach DONE.
  always_ff @(posedge clk) begin
    if (srst) begin
      r_op_cnt <= 16'h0000;
    end else if (w_done_nxt && (r_op_cnt != 16'hFFFF)) begin
      r_op_cnt <= r_op_cnt + 16'h0001;
    end else begin
      r_op_cnt <= r_op_cnt;
    end
  end

  assign op_cnt = r_op_cnt;
`endif

endmodule
